// File: rtl/alu_share_arb_if.sv
// ============================================================================
// Module      : alu_share_arb_if
// Description : Client request/response channels and shared-ALU drive/return
//               signals for alu_share_arb. The arbiter uses the slave modport;
//               the clients plus the ALU sit on the master side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_share_arb_if #(
    parameter int N    = 32,
    parameter int NREQ = 2
);
    // Requester operation channel (requester i at slice i)
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ*3-1:0] req_cont;

    // Requester response channel
    logic [NREQ-1:0]   resp_valid;
    logic [NREQ-1:0]   resp_ready;
    logic [N-1:0]      resp_result;
    logic              resp_zero;

    // Shared combinational ALU
    logic [N-1:0]      alu_a;
    logic [N-1:0]      alu_b;
    logic [2:0]        alu_cont;
    logic [N-1:0]      alu_result;
    logic              alu_zero;

    modport master (
        output req_valid, req_a, req_b, req_cont, resp_ready, alu_result, alu_zero,
        input  req_ready, resp_valid, resp_result, resp_zero, alu_a, alu_b, alu_cont
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cont, resp_ready, alu_result, alu_zero,
        output req_ready, resp_valid, resp_result, resp_zero, alu_a, alu_b, alu_cont
    );
endinterface

`default_nettype wire

// File: rtl/alu_share_arb.sv
// ============================================================================
// Module      : alu_share_arb
// Description : Round-robin time-sharing of one combinational ALU between NREQ
//               requesters. IDLE arbitrates and latches operands, EXEC drives
//               the ALU for one cycle and captures its outputs, RESP holds the
//               result until the granted requester accepts it.
//               Optional macro ALU_SHARE_ARB_FASTPATH_EN: re-arbitrate during
//               the response handshake and go straight to EXEC (1 op / 2 clk).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_share_arb #(
    parameter int N    = 32,
    parameter int NREQ = 2
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    alu_share_arb_if.slave                bus,
    output logic                          busy,
    output logic [$clog2(NREQ)-1:0]       gnt_id
);

    localparam int c_IDW = $clog2(NREQ);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;

    logic [c_IDW-1:0] r_rr_ptr;
    logic [c_IDW-1:0] r_gnt_id;
    logic [N-1:0]     r_op_a;
    logic [N-1:0]     r_op_b;
    logic [2:0]       r_op_cont;
    logic [N-1:0]     r_res;
    logic             r_zero;

    logic [c_IDW-1:0] w_next_ptr;
    logic [c_IDW-1:0] w_arb_ptr;
    logic             w_arb_found;
    logic [c_IDW-1:0] w_arb_idx;
    logic [N-1:0]     w_sel_a;
    logic [N-1:0]     w_sel_b;
    logic [2:0]       w_sel_cont;

    logic             w_grant;
    logic             w_resp_hs;
    logic [NREQ-1:0]  w_req_ready;
    logic [NREQ-1:0]  w_resp_valid;

    // The requester after the one just served gets first look next time
    assign w_next_ptr = (r_gnt_id == c_IDW'(NREQ - 1)) ? '0 : r_gnt_id + 1'b1;

`ifdef ALU_SHARE_ARB_FASTPATH_EN
    // During RESP the search already starts from the post-handshake pointer
    assign w_arb_ptr = (r_state == c_ST_RESP) ? w_next_ptr : r_rr_ptr;
`else
    assign w_arb_ptr = r_rr_ptr;
`endif

    // Round-robin search from w_arb_ptr and payload mux of the winner
    always_comb begin
        int               v_cand;
        logic [c_IDW-1:0] v_idx;
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        w_sel_a     = '0;
        w_sel_b     = '0;
        w_sel_cont  = '0;
        for (int k = 0; k < NREQ; k++) begin
            v_cand = int'(w_arb_ptr) + k;
            if (v_cand >= NREQ) begin
                v_cand = v_cand - NREQ;
            end
            v_idx = c_IDW'(v_cand);
            if (!w_arb_found && bus.req_valid[v_idx]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = v_idx;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (w_arb_idx == c_IDW'(k)) begin
                w_sel_a    = bus.req_a[k*N +: N];
                w_sel_b    = bus.req_b[k*N +: N];
                w_sel_cont = bus.req_cont[k*3 +: 3];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state, handshake strobes and per-requester ready/valid
    always_comb begin
        w_state_nxt  = r_state;
        w_grant      = 1'b0;
        w_resp_hs    = 1'b0;
        w_req_ready  = '0;
        w_resp_valid = '0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_arb_found) begin
                    w_req_ready[w_arb_idx] = 1'b1;
                    w_grant                = 1'b1;
                    w_state_nxt            = c_ST_EXEC;
                end
            end
            c_ST_EXEC: begin
                w_state_nxt = c_ST_RESP;
            end
            c_ST_RESP: begin
                w_resp_valid[r_gnt_id] = 1'b1;
                if (bus.resp_ready[r_gnt_id]) begin
                    w_resp_hs   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
`ifdef ALU_SHARE_ARB_FASTPATH_EN
                    if (w_arb_found) begin
                        w_req_ready[w_arb_idx] = 1'b1;
                        w_grant                = 1'b1;
                        w_state_nxt            = c_ST_EXEC;
                    end
`endif
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Operand capture on grant, ALU capture in EXEC, pointer advance on response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr  <= '0;
            r_gnt_id  <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_cont <= '0;
            r_res     <= '0;
            r_zero    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_op_a    <= w_sel_a;
                r_op_b    <= w_sel_b;
                r_op_cont <= w_sel_cont;
                r_gnt_id  <= w_arb_idx;
            end
            if (r_state == c_ST_EXEC) begin
                r_res  <= bus.alu_result;
                r_zero <= bus.alu_zero;
            end
            if (w_resp_hs) begin
                r_rr_ptr <= w_next_ptr;
            end
        end
    end

    // ALU is fed from registers in every state so its inputs never glitch
    assign bus.alu_a       = r_op_a;
    assign bus.alu_b       = r_op_b;
    assign bus.alu_cont    = r_op_cont;
    assign bus.resp_result = r_res;
    assign bus.resp_zero   = r_zero;
    assign bus.req_ready   = w_req_ready;
    assign bus.resp_valid  = w_resp_valid;
    assign busy            = (r_state != c_ST_IDLE);
    assign gnt_id          = r_gnt_id;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arb.sv
// ============================================================================
// Module      : tb_alu_share_arb
// Description : Scoreboard bench for alu_share_arb (N=32, NREQ=2) with a
//               small behavioural ALU on the shared-ALU side. Build with
//               ALU_SHARE_ARB_FASTPATH_EN to expect 2-cycle grant spacing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_share_arb;

    localparam int N    = 32;
    localparam int NREQ = 2;

    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

`ifdef ALU_SHARE_ARB_FASTPATH_EN
    localparam int c_SPACING = 2;
`else
    localparam int c_SPACING = 3;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy;
    logic gnt_id;

    always #5 clk = ~clk;

    alu_share_arb_if #(.N(N), .NREQ(NREQ)) bus ();

    alu_share_arb #(.N(N), .NREQ(NREQ)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .busy   (busy),
        .gnt_id (gnt_id)
    );

    // Behavioural shared ALU
    always_comb begin
        case (bus.alu_cont)
            c_ALU_AND: bus.alu_result = bus.alu_a & bus.alu_b;
            c_ALU_OR:  bus.alu_result = bus.alu_a | bus.alu_b;
            c_ALU_ADD: bus.alu_result = bus.alu_a + bus.alu_b;
            c_ALU_SUB: bus.alu_result = bus.alu_a - bus.alu_b;
            c_ALU_SLT: bus.alu_result = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
            default:   bus.alu_result = '0;
        endcase
    end
    assign bus.alu_zero = (bus.alu_result == '0);

    typedef struct {
        int           id;
        logic [N-1:0] res;
        logic         zero;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // Monitor: compare every presented response against the scoreboard head
    always @(negedge clk) begin
        if (rst_n) begin
            chk("req_ready_onehot", 64'($countones(bus.req_ready) <= 1), 64'd1);
            chk("resp_valid_onehot", 64'($countones(bus.resp_valid) <= 1), 64'd1);
            if (|bus.resp_valid) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL resp_unexpected: resp_valid=%b result=0x%0h, expected no response", bus.resp_valid, bus.resp_result);
                end else begin
                    chk("resp_id", 64'(onehot_idx(bus.resp_valid)), 64'(q[0].id));
                    chk("resp_result", 64'(bus.resp_result), 64'(q[0].res));
                    chk("resp_zero", 64'(bus.resp_zero), 64'(q[0].zero));
                    if ((bus.resp_valid & bus.resp_ready) != '0) begin
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic set_req(input int id, input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] c);
        bus.req_a[id*N +: N]  = a;
        bus.req_b[id*N +: N]  = b;
        bus.req_cont[id*3 +: 3] = c;
        bus.req_valid[id]     = 1'b1;
    endtask

    task automatic wait_grant(input int id, input string name);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.req_ready[id]) break;
        end
        chk(name, 64'(bus.req_ready[id]), 64'd1);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40; k++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        chk(name, 64'(q.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        int last;

        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_cont   = '0;
        bus.resp_ready = '0;

        // Reset state
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_gnt_id", 64'(gnt_id), 64'd0);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_result", 64'(bus.resp_result), 64'd0);
        chk("rst_resp_zero", 64'(bus.resp_zero), 64'd0);
        chk("rst_alu_a", 64'(bus.alu_a), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.resp_ready = 2'b11;

        // A: req0 ADD 5+7, latency and result
        @(posedge clk); #1;
        set_req(0, 32'd5, 32'd7, c_ALU_ADD);
        q.push_back('{0, 32'd12, 1'b0});
        @(negedge clk);
        chk("A_req_ready_n", 64'(bus.req_ready), 64'b01);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        chk("A_exec_busy", 64'(busy), 64'd1);
        chk("A_exec_no_resp", 64'(bus.resp_valid), 64'd0);
        chk("A_alu_a", 64'(bus.alu_a), 64'd5);
        chk("A_alu_cont", 64'(bus.alu_cont), 64'(c_ALU_ADD));
        @(negedge clk);
        chk("A_resp_valid_n2", 64'(bus.resp_valid), 64'b01);
        chk("A_gnt_id", 64'(gnt_id), 64'd0);
        @(negedge clk);
        chk("A_back_idle", 64'(busy), 64'd0);

        // B: req1 SUB 9-9 with the response stalled; other ready bit ignored
        bus.resp_ready = 2'b01;
        @(posedge clk); #1;
        set_req(1, 32'h9, 32'h9, c_ALU_SUB);
        q.push_back('{1, 32'd0, 1'b1});
        wait_grant(1, "B_grant");
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("B_stall_valid", 64'(bus.resp_valid), 64'b10);
            chk("B_stall_busy", 64'(busy), 64'd1);
        end
        @(posedge clk); #1;
        bus.resp_ready = 2'b10;
        @(negedge clk);
        chk("B_release_valid", 64'(bus.resp_valid), 64'b10);
        @(negedge clk);
        chk("B_idle_busy", 64'(busy), 64'd0);
        chk("B_idle_valid", 64'(bus.resp_valid), 64'd0);
        bus.resp_ready = 2'b11;

        // C: both requesters continuously valid from reset
        pulse_reset();
        set_req(0, 32'hF0, 32'h3C, c_ALU_AND);
        set_req(1, 32'd3, 32'd4, c_ALU_SLT);
        q.push_back('{0, 32'h30, 1'b0});
        q.push_back('{1, 32'd1, 1'b0});
        q.push_back('{0, 32'h30, 1'b0});
        q.push_back('{1, 32'd1, 1'b0});
        grants = 0;
        last   = 0;
        for (int cyc = 1; cyc <= 60 && grants < 4; cyc++) begin
            @(negedge clk);
            if (|bus.req_ready) begin
                chk("C_order", 64'(onehot_idx(bus.req_ready)), 64'(grants % 2));
                if (grants > 0) chk("C_spacing", 64'(cyc - last), 64'(c_SPACING));
                last = cyc;
                grants++;
            end
        end
        chk("C_grants", 64'(grants), 64'd4);
        @(posedge clk); #1;
        bus.req_valid = '0;
        drain("C_drain");
        repeat (2) @(negedge clk);

        // D: reset in the middle of EXEC discards the op and rewinds the pointer
        @(posedge clk); #1;
        set_req(0, 32'h5, 32'hA, c_ALU_OR);
        q.push_back('{0, 32'hF, 1'b0});
        wait_grant(0, "D_pre_grant");
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        drain("D_pre_drain");
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        set_req(0, 32'd1, 32'd1, c_ALU_ADD);
        wait_grant(0, "D_grant");
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        chk("D_exec_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("D_rst_busy", 64'(busy), 64'd0);
        chk("D_rst_result", 64'(bus.resp_result), 64'd0);
        chk("D_rst_gnt", 64'(gnt_id), 64'd0);
        chk("D_rst_alu_a", 64'(bus.alu_a), 64'd0);
        chk("D_rst_valid", 64'(bus.resp_valid), 64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_req(0, 32'hFF, 32'h0F, c_ALU_AND);
        set_req(1, 32'd1, 32'd2, c_ALU_ADD);
        q.push_back('{0, 32'h0F, 1'b0});
        @(negedge clk);
        chk("D_ptr_reset", 64'(bus.req_ready), 64'b01);
        @(posedge clk); #1;
        bus.req_valid = '0;
        drain("D_drain");
        repeat (2) @(negedge clk);

        // E: req0 loses to req1 (pointer at 1) then withdraws
        @(posedge clk); #1;
        set_req(0, 32'h11, 32'h22, c_ALU_ADD);
        set_req(1, 32'h30, 32'h03, c_ALU_OR);
        q.push_back('{1, 32'h33, 1'b0});
        @(negedge clk);
        chk("E_winner", 64'(bus.req_ready), 64'b10);
        @(posedge clk); #1;
        bus.req_valid = '0;
        drain("E_drain");
        repeat (6) begin
            @(negedge clk);
            chk("E_no_resp", 64'(bus.resp_valid), 64'd0);
        end
        chk("E_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Time-shares one combinational ALU instance between NREQ independent requesters.
- Each requester presents an operation (A, B, ALU control code) with a valid/ready handshake.
- The block arbitrates round-robin, drives the shared ALU from registered operands, and returns a registered result and zero flag through a per-requester valid/ready response channel.
- It sits between the ALU and client units (e.g. branch-compare and address-generation helpers in later pipeline work).

Parameters:
- N, 32, operand/result width; must match the shared ALU's N.
- NREQ, 2, number of requesters; legal range 2..8.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  NREQ*N  operand A, requester i at bits [i*N +: N].
- req_b  in  NREQ*N  operand B, same packing.
- req_cont  in  NREQ*3  ALU control code (ALU_* encodings from common.svh), requester i at [i*3 +: 3].
- resp_valid  out  NREQ  per-requester result valid; at most one bit high.
- resp_ready  in  NREQ  per-requester result accept.
- resp_result  out  N  registered ALU result; meaningful only to the requester whose resp_valid bit is high.
- resp_zero  out  1  registered ALU zero flag.
- alu_a  out  N  to ALU A.
- alu_b  out  N  to ALU B.
- alu_cont  out  3  to ALU ALUcont.
- alu_result  in  N  from ALU result.
- alu_zero  in  1  from ALU zero.
- busy  out  1  high in any state other than IDLE.
- gnt_id  out  $clog2(NREQ)  index of the current or last granted requester.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rr_ptr=0; gnt_id=0.
  - Operand registers, resp_result and resp_zero all cleared to 0.
  - req_ready=0, resp_valid=0, busy=0.
  - Any in-flight operation is discarded; no response is ever produced for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Select the first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, … modulo NREQ.
  - req_ready[i]=1 combinationally, in the same cycle, for the selected i only.
  - On that edge: latch req_a/req_b/req_cont of i into operand registers, set gnt_id=i, go to EXEC.
  - No valid request: stay in IDLE, all req_ready=0.
- EXEC (exactly one cycle):
  - alu_a/alu_b/alu_cont are driven from the operand registers.
  - At the closing edge, capture alu_result into resp_result and alu_zero into resp_zero; go to RESP.
- RESP:
  - resp_valid[gnt_id]=1. resp_result and resp_zero are held stable until the handshake.
  - On resp_ready[gnt_id]=1: rr_ptr=(gnt_id+1) mod NREQ, go to IDLE.
  - resp_ready bits of other requesters are ignored.
- Latency: handshake in cycle n → resp_valid high in cycle n+2. Base throughput: one operation per 3 cycles.
- ALU drive outside EXEC: alu_* keep driving the operand registers in all states, so they are stable and glitch-free.
- Control codes: passed through unmodified. Undefined codes yield whatever the ALU returns, with no error signalling.
- Requester rules:
  - A requester may drop req_valid before being granted; the operation is simply not performed.
  - Payload must be held stable while valid=1 and ready=0.
- Fairness: a requester that has just been served has lowest priority at the next arbitration. With all requesters continuously valid, the grant order is 0, 1, …, NREQ-1, 0.
- Simultaneous events: in RESP, a new req_valid is not accepted in the same cycle as the resp handshake (base build); it is arbitrated in the following IDLE cycle.
- Wrap-around: rr_ptr wraps from NREQ-1 to 0. For non-power-of-2 NREQ, values ≥ NREQ are unreachable.

Optional Feature:
- Macro: ALU_SHARE_ARB_FASTPATH_EN.
- Defined:
  - In RESP, when resp_ready[gnt_id]=1 and any req_valid is high, arbitration is done in the same cycle using the updated pointer (gnt_id+1).
  - The winner gets req_ready that cycle, its operands are latched, and the FSM goes directly to EXEC, skipping IDLE.
  - Back-to-back throughput becomes one operation per 2 cycles.
- Undefined: req_ready is always 0 outside IDLE; throughput is 1 per 3 cycles.

Test Plan:
- NREQ=2, req 0: ADD 5+7 → req_ready[0] in cycle n, resp_valid[0] in cycle n+2, resp_result=12, resp_zero=0, gnt_id=0.
- req 1: SUB 0x9 − 0x9 with resp_ready held 0 for 5 cycles → resp_valid[1] and result=0, zero=1 held stable throughout; release → IDLE next cycle, busy=0.
- Both requesters valid continuously after reset (req0 AND 0xF0&0x3C, req1 SLT 3<4) → order req0 (0x30), req1 (1), req0, req1…; never two bits of req_ready or resp_valid high at once.
- rst_n pulsed low during EXEC for req 0 → outputs cleared immediately, no resp_valid for that op, next grant goes to req 0 (rr_ptr=0).
- req 0 raises valid for 1 cycle but loses to an earlier grant, then drops valid → no operation performed for req 0, no response.
- With ALU_SHARE_ARB_FASTPATH_EN, both valid, resp_ready tied 1 → resp_valid alternates between requesters every 2 cycles; without the macro, every 3 cycles.
